// File: rtl/ahb_arbiter_if.sv
// Bus-side signal bundle between AHB requesters and the round-robin arbiter.
// The master modport is the requester/bus side; the slave modport is the arbiter.
interface ahb_arbiter_if #(
  parameter int NUM_MASTERS = 4,
  parameter int MW          = $clog2(NUM_MASTERS)
);
  logic [NUM_MASTERS-1:0] Hbusreq;
  logic [NUM_MASTERS-1:0] Hlock;
  logic [1:0]             Htrans;
  logic [2:0]             Hburst;
  logic                   Hreadyout;
  logic [NUM_MASTERS-1:0] Hgrant;
  logic [MW-1:0]          Hmaster;
  logic                   Hmastlock;

  modport master (
    output Hbusreq, Hlock, Htrans, Hburst, Hreadyout,
    input  Hgrant, Hmaster, Hmastlock
  );

  modport slave (
    input  Hbusreq, Hlock, Htrans, Hburst, Hreadyout,
    output Hgrant, Hmaster, Hmastlock
  );
endinterface

// File: rtl/ahb_arbiter.sv
// Round-robin AHB arbiter. Tracks the owner's burst progress so that grants
// only move at legal boundaries: never inside a fixed-length burst and never
// while the owner holds Hlock. Hmaster/Hmastlock follow the owner one
// accepted transfer later, matching the AHB data-phase pipeline.
module ahb_arbiter #(
  parameter int NUM_MASTERS = 4,
  parameter int MW          = $clog2(NUM_MASTERS)
) (
  input logic         clock,
  input logic         Hreset,
  ahb_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BURST,
    ST_INCR
  } state_t;

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_BUSY   = 2'b01;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;

  localparam logic [2:0] BU_SINGLE = 3'b000;
  localparam logic [2:0] BU_INCR   = 3'b001;

  state_t        state, state_nxt;
  logic [3:0]    cnt, cnt_nxt;
  logic [MW-1:0] own, own_nxt;
  logic [MW-1:0] hmaster_p1;
  logic          hmastlock_p1;
  logic          arb;
  logic [4:0]    len;

  // Beats in a burst; 0 marks the undefined-length INCR.
  function automatic logic [4:0] burst_len(input logic [2:0] burst);
    case (burst)
      3'b000:          return 5'd1;
      3'b001:          return 5'd0;
      3'b010, 3'b011:  return 5'd4;
      3'b100, 3'b101:  return 5'd8;
      default:         return 5'd16;
    endcase
  endfunction

  // First requester after cur, wrapping back to cur; keeps cur when nobody asks.
  function automatic logic [MW-1:0] rr_pick(input logic [MW-1:0] cur,
                                            input logic [NUM_MASTERS-1:0] req);
    logic [MW-1:0] pick;
    logic          found;
    pick  = cur;
    found = 1'b0;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      int idx;
      idx = (int'(cur) + i) % NUM_MASTERS;
      if (!found && req[idx]) begin
        pick  = MW'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  // Next burst state, beat count and owner; everything holds while the slave stalls.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    own_nxt   = own;
    arb       = 1'b0;
    len       = burst_len(bus.Hburst);
    if (bus.Hreadyout) begin
      case (bus.Htrans)
        TR_IDLE: begin
          state_nxt = ST_IDLE;
          cnt_nxt   = 4'd0;
        end
        TR_BUSY: begin
        end
        TR_NONSEQ: begin
          if (bus.Hburst == BU_INCR) begin
            state_nxt = ST_INCR;
            cnt_nxt   = 4'd0;
          end else if (len > 5'd1) begin
            state_nxt = ST_BURST;
            cnt_nxt   = 4'(len - 5'd1);
          end else begin
            state_nxt = ST_IDLE;
            cnt_nxt   = 4'd0;
          end
        end
        TR_SEQ: begin
          if (state == ST_BURST) begin
            if (cnt == 4'd1) begin
              state_nxt = ST_IDLE;
              cnt_nxt   = 4'd0;
            end else begin
              cnt_nxt = cnt - 4'd1;
            end
          end
        end
      endcase

      // A last fixed-burst beat regrants even if the owner drops Hbusreq on the same edge.
      arb = (bus.Htrans == TR_IDLE)
          | ((bus.Htrans == TR_NONSEQ) && (bus.Hburst == BU_SINGLE))
          | ((bus.Htrans == TR_SEQ) && (state == ST_BURST) && (cnt == 4'd1))
          | ((state == ST_INCR) && !bus.Hbusreq[own]);

      if (arb && !bus.Hlock[own]) begin
        own_nxt = rr_pick(own, bus.Hbusreq);
      end
    end
  end

  // Arbitration state register; reset parks the bus on master 0.
  always_ff @(posedge clock) begin
    if (Hreset) begin
      state <= ST_IDLE;
      cnt   <= 4'd0;
      own   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      own   <= own_nxt;
    end
  end

  // Data-phase owner and lock qualifier advance with each accepted transfer.
  always_ff @(posedge clock) begin
    if (Hreset) begin
      hmaster_p1   <= '0;
      hmastlock_p1 <= 1'b0;
    end else if (bus.Hreadyout) begin
      hmaster_p1   <= own;
      hmastlock_p1 <= bus.Hlock[own];
    end
  end

  assign bus.Hgrant    = NUM_MASTERS'(1) << own;
  assign bus.Hmaster   = hmaster_p1;
  assign bus.Hmastlock = hmastlock_p1;

endmodule

// File: tb/tb_ahb_arbiter.sv
// Directed bench for ahb_arbiter: each step drives the bus, queues the
// expected grant/data-phase owner/lock, and compares after the clock edge.
module tb_ahb_arbiter;

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] BUSY   = 2'b01;
  localparam logic [1:0] NONSEQ = 2'b10;
  localparam logic [1:0] SEQ    = 2'b11;

  typedef struct {
    string      tag;
    logic [3:0] grant;
    logic [1:0] master;
    logic       lock;
  } exp_t;

  logic clock;
  logic Hreset;
  int   compared;
  int   mismatched;
  exp_t sb[$];

  ahb_arbiter_if #(.NUM_MASTERS(4)) bus_if ();

  ahb_arbiter #(.NUM_MASTERS(4)) dut (
    .clock (clock),
    .Hreset(Hreset),
    .bus   (bus_if)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic drive(input logic [3:0] req, input logic [3:0] lock,
                       input logic [1:0] trans, input logic [2:0] burst,
                       input logic ready);
    bus_if.Hbusreq   = req;
    bus_if.Hlock     = lock;
    bus_if.Htrans    = trans;
    bus_if.Hburst    = burst;
    bus_if.Hreadyout = ready;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    compared++;
    assert (obs === exp_v) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Queue the expectation for the state after the next edge, then compare it.
  task automatic step(input string tag, input logic [3:0] g,
                      input logic [1:0] m, input logic l);
    exp_t e;
    sb.push_back('{tag: tag, grant: g, master: m, lock: l});
    @(posedge clock);
    #1;
    e = sb.pop_front();
    check({e.tag, ".grant"},  {4'b0, bus_if.Hgrant},   {4'b0, e.grant});
    check({e.tag, ".master"}, {6'b0, bus_if.Hmaster},  {6'b0, e.master});
    check({e.tag, ".lock"},   {7'b0, bus_if.Hmastlock}, {7'b0, e.lock});
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;

    // Reset held two cycles with random bus activity.
    Hreset = 1'b1;
    drive(4'($urandom), 4'($urandom), 2'($urandom), 3'($urandom), 1'($urandom));
    step("rst0", 4'b0001, 2'd0, 1'b0);
    drive(4'($urandom), 4'($urandom), 2'($urandom), 3'($urandom), 1'($urandom));
    step("rst1", 4'b0001, 2'd0, 1'b0);

    // Release with no requests: parked on master 0.
    Hreset = 1'b0;
    drive(4'b0000, 4'b0000, IDLE, 3'b000, 1'b1);
    step("park", 4'b0001, 2'd0, 1'b0);

    // Round robin with back-to-back SINGLEs.
    drive(4'b1111, 4'b0000, NONSEQ, 3'b000, 1'b1);
    step("rr1", 4'b0010, 2'd0, 1'b0);
    step("rr2", 4'b0100, 2'd1, 1'b0);
    step("rr3", 4'b1000, 2'd2, 1'b0);
    step("rr4", 4'b0001, 2'd3, 1'b0);
    step("rr5", 4'b0010, 2'd0, 1'b0);

    // Master 1 INCR4 with a 3-cycle stall on beat 2.
    drive(4'b1111, 4'b0000, NONSEQ, 3'b011, 1'b1);
    step("inc4_b1", 4'b0010, 2'd1, 1'b0);
    drive(4'b1111, 4'b0000, SEQ, 3'b011, 1'b0);
    step("inc4_w1", 4'b0010, 2'd1, 1'b0);
    step("inc4_w2", 4'b0010, 2'd1, 1'b0);
    step("inc4_w3", 4'b0010, 2'd1, 1'b0);
    drive(4'b1111, 4'b0000, SEQ, 3'b011, 1'b1);
    step("inc4_b2", 4'b0010, 2'd1, 1'b0);
    drive(4'b1111, 4'b0000, BUSY, 3'b011, 1'b1);
    step("inc4_busy", 4'b0010, 2'd1, 1'b0);
    drive(4'b1111, 4'b0000, SEQ, 3'b011, 1'b1);
    step("inc4_b3", 4'b0010, 2'd1, 1'b0);
    step("inc4_b4", 4'b0100, 2'd1, 1'b0);

    // Master 2 locked: two SINGLEs, then lock drops and the bus moves on.
    drive(4'b1111, 4'b0100, NONSEQ, 3'b000, 1'b1);
    step("lock_s1", 4'b0100, 2'd2, 1'b1);
    step("lock_s2", 4'b0100, 2'd2, 1'b1);
    drive(4'b1111, 4'b0000, IDLE, 3'b000, 1'b1);
    step("lock_rel", 4'b1000, 2'd2, 1'b0);

    // Master 3 undefined-length INCR, then drops its request mid-burst.
    drive(4'b1111, 4'b0000, NONSEQ, 3'b001, 1'b1);
    step("incr_b1", 4'b1000, 2'd3, 1'b0);
    drive(4'b1111, 4'b0000, SEQ, 3'b001, 1'b1);
    for (int b = 2; b <= 6; b++) step($sformatf("incr_b%0d", b), 4'b1000, 2'd3, 1'b0);
    drive(4'b0111, 4'b0000, SEQ, 3'b001, 1'b1);
    step("incr_drop", 4'b0001, 2'd3, 1'b0);

    // Master 0 SINGLE hands over to master 2, the only requester.
    drive(4'b0100, 4'b0000, NONSEQ, 3'b000, 1'b1);
    step("hand_m2", 4'b0100, 2'd0, 1'b0);

    // Master 2 WRAP8, reset asserted during beat 5.
    drive(4'b1111, 4'b0000, NONSEQ, 3'b100, 1'b1);
    step("wrap8_b1", 4'b0100, 2'd2, 1'b0);
    drive(4'b1111, 4'b0000, SEQ, 3'b100, 1'b1);
    for (int b = 2; b <= 4; b++) step($sformatf("wrap8_b%0d", b), 4'b0100, 2'd2, 1'b0);
    Hreset = 1'b1;
    step("wrap8_rst", 4'b0001, 2'd0, 1'b0);
    Hreset = 1'b0;

    // Fresh arbitration after the abandoned burst.
    drive(4'b1111, 4'b0000, IDLE, 3'b000, 1'b1);
    step("post_rst1", 4'b0010, 2'd0, 1'b0);
    drive(4'b1111, 4'b0000, NONSEQ, 3'b000, 1'b1);
    step("post_rst2", 4'b0100, 2'd1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
